// File: rtl/dled_scan_ctrl.sv
// Multiplexed 7-segment scan controller: refresh divider, digit rotation, anti-ghost
// blanking, frame-coherent snapshot, hex decode and leading-zero suppression.
module dled_scan_ctrl #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{SEL_ACTIVE_LOW}};
    localparam logic [7:0]        SEG_OFF   = {8{SEG_ACTIVE_LOW}};

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                slot_end;
    logic                frame_end;
    logic                snap_load;
    logic                load_pend;
    logic [4*DIGITS-1:0] snap_data;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blank;
    logic                snap_lz;

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == IDX_MAX);
    assign snap_load = load_pend || !en || frame_end;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Inputs are captured only at frame boundaries so a frame never mixes old and new data.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            load_pend  <= 1'b1;
            snap_data  <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
            snap_lz    <= 1'b0;
        end else begin
            load_pend <= 1'b0;
            if (snap_load) begin
                snap_data  <= disp_data;
                snap_dp    <= dp_i;
                snap_blank <= blank_i;
                snap_lz    <= lz_en;
            end
        end
    end

    logic in_blank;
    if (BLANK_CYCLES > 0) begin : g_blank
        assign in_blank = (cnt < BLANK_END);
    end else begin : g_noblank
        assign in_blank = 1'b0;
    end

    // Stage p0: digit mux, effective blanking and decode for the current slot.
    logic [DIGITS-1:0] sel_p0;
    logic [3:0]        nib_p0;
    logic              dp_p0;
    logic              blank_p0;
    logic              zero_above;
    logic              vld_p0;
    logic [7:0]        seg_p0;

    always_comb begin
        sel_p0     = '0;
        nib_p0     = 4'h0;
        dp_p0      = 1'b0;
        blank_p0   = 1'b0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            // zero_above: this nibble and every more-significant one are zero
            zero_above = zero_above && (snap_data[4*i +: 4] == 4'h0);
            if (idx == IDX_W'(i)) begin
                sel_p0[i] = 1'b1;
                nib_p0    = snap_data[4*i +: 4];
                dp_p0     = snap_dp[i];
                blank_p0  = snap_blank[i] || (snap_lz && (i != 0) && zero_above);
            end
        end
    end

    assign vld_p0 = en && !load_pend && !in_blank && !blank_p0;
    assign seg_p0 = {dp_p0, hex7(nib_p0)};

    // Stage p1: registered pin drivers, polarity applied after decode.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sel        <= SEL_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            sel        <= vld_p0 ? (sel_p0 ^ SEL_OFF) : SEL_OFF;
            seg        <= vld_p0 ? (seg_p0 ^ SEG_OFF) : SEG_OFF;
            frame_done <= en && frame_end;
        end
    end

endmodule

// File: tb/tb_dled_scan_ctrl.sv
// Bench for dled_scan_ctrl: directed literal checks plus randomized stimulus
// compared every cycle against a frame/slot arithmetic model.
module tb_dled_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en_a = 1'b0;
    logic [15:0] data_a = '0;
    logic [3:0]  dp_a = '0, blank_a = '0;
    logic        lz_a = 1'b0;
    logic [3:0]  sel_a;
    logic [7:0]  seg_a;
    logic        fd_a;

    logic        en_b = 1'b0;
    logic [3:0]  data_b = '0;
    logic [0:0]  dp_b = '0, blank_b = '0;
    logic        lz_b = 1'b0;
    logic [0:0]  sel_b;
    logic [7:0]  seg_b;
    logic        fd_b;

    dled_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
                     .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_a (
        .Clk(clk), .Rst(rst), .en(en_a), .disp_data(data_a), .dp_i(dp_a),
        .blank_i(blank_a), .lz_en(lz_a), .sel(sel_a), .seg(seg_a), .frame_done(fd_a));

    dled_scan_ctrl #(.DIGITS(1), .SCAN_DIV(3), .BLANK_CYCLES(0),
                     .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) dut_b (
        .Clk(clk), .Rst(rst), .en(en_b), .disp_data(data_b), .dp_i(dp_b),
        .blank_i(blank_b), .lz_en(lz_b), .sel(sel_b), .seg(seg_b), .frame_done(fd_b));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Reference model: position within the frame drives everything.
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int  dig_p [2] = '{4, 1};
    int  div_p [2] = '{4, 3};
    int  blk_p [2] = '{1, 0};
    bit  seg_al[2] = '{1'b1, 1'b0};
    bit  sel_al[2] = '{1'b1, 1'b0};

    int          pos_m [2];
    bit          pend_m[2];
    logic [63:0] sd_m  [2];
    logic [15:0] sdp_m [2];
    logic [15:0] sbl_m [2];
    bit          slz_m [2];
    logic [15:0] esel  [2];
    logic [7:0]  eseg  [2];
    bit          efd   [2];
    bit          model_ok = 1'b0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pos_m[d]  = 0;
            pend_m[d] = 1'b1;
            sd_m[d]   = '0;
            sdp_m[d]  = '0;
            sbl_m[d]  = '0;
            slz_m[d]  = 1'b0;
            esel[d]   = sel_al[d] ? 16'hFFFF : 16'h0000;
            eseg[d]   = seg_al[d] ? 8'hFF : 8'h00;
            efd[d]    = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input bit en, input logic [63:0] din,
                              input logic [15:0] dpin, input logic [15:0] blin, input bit lzin);
        int frame_len, digit, phase;
        bit lz_hide, show;
        logic [15:0] s;
        logic [7:0]  g;
        frame_len = dig_p[d] * div_p[d];
        digit     = pos_m[d] / div_p[d];
        phase     = pos_m[d] % div_p[d];
        lz_hide   = slz_m[d] && (digit != 0) && ((sd_m[d] >> (4 * digit)) == 64'd0);
        show      = en && !pend_m[d] && (phase >= blk_p[d]) && !sbl_m[d][digit] && !lz_hide;
        s = show ? (16'd1 << digit) : 16'd0;
        g = show ? {sdp_m[d][digit], hex_tab[sd_m[d][4*digit +: 4]]} : 8'd0;
        esel[d] = sel_al[d] ? ~s : s;
        eseg[d] = seg_al[d] ? ~g : g;
        efd[d]  = en && (pos_m[d] == frame_len - 1);
        if (pend_m[d] || !en || (pos_m[d] == frame_len - 1)) begin
            sd_m[d]  = din;
            sdp_m[d] = dpin;
            sbl_m[d] = blin;
            slz_m[d] = lzin;
        end
        pend_m[d] = 1'b0;
        pos_m[d]  = en ? (pos_m[d] + 1) % frame_len : 0;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            model_reset();
            model_ok = 1'b1;
        end else begin
            model_step(0, en_a, {48'd0, data_a}, {12'd0, dp_a}, {12'd0, blank_a}, lz_a);
            model_step(1, en_b, {60'd0, data_b}, {15'd0, dp_b}, {15'd0, blank_b}, lz_b);
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        logic [3:0] act;
        @(negedge clk);
        cyc++;
        if (model_ok) begin
            act = ~sel_a;
            check("sel_a", {12'd0, sel_a}, {12'd0, esel[0][3:0]});
            check("seg_a", {8'd0, seg_a}, {8'd0, eseg[0]});
            check("fd_a", {15'd0, fd_a}, {15'd0, efd[0]});
            check("onehot_a", {15'd0, ($countones(act) > 1)}, 16'd0);
            check("sel_b", {15'd0, sel_b}, {15'd0, esel[1][0]});
            check("seg_b", {8'd0, seg_b}, {8'd0, eseg[1]});
            check("fd_b", {15'd0, fd_b}, {15'd0, efd[1]});
        end
    end

    function automatic logic [3:0] rnib();
        return ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    endfunction

    int         lit_e  [10] = '{1, 2, 5, 6, 10, 14, 18, 22, 26, 30};
    logic [3:0] lit_sel[10] = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] lit_seg[10] = '{8'hFF, 8'h99, 8'hFF, 8'hB0, 8'hA4, 8'hF9, 8'hA1, 8'hC6, 8'h83, 8'h88};

    initial begin
        int fa, fb, bad, seen;
        bit found;
        en_a = 1'b1; data_a = 16'h1234;
        en_b = 1'b1; data_b = 4'h1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Startup and frame coherence.
        fa = 0; fb = 0;
        for (int e = 1; e <= 32; e++) begin
            @(negedge clk);
            for (int k = 0; k < 10; k++) begin
                if (lit_e[k] == e) begin
                    check("lit_sel", {12'd0, sel_a}, {12'd0, lit_sel[k]});
                    check("lit_seg", {8'd0, seg_a}, {8'd0, lit_seg[k]});
                end
            end
            if (fd_a) fa++;
            if (fd_b && e <= 30) fb++;
            if (e == 16) check("lit_fd_a_e16", {15'd0, fd_a}, 16'd1);
            if (e == 2) begin
                check("lit_sel_b", {15'd0, sel_b}, 16'd1);
                check("lit_seg_b", {8'd0, seg_b}, 16'h0006);
            end
            if (e == 9) data_a = 16'hABCD;
        end
        check("fd_a_count", 16'(fa), 16'd2);
        check("fd_b_count", 16'(fb), 16'd10);

        // Leading-zero suppression.
        data_a = 16'h0005; lz_a = 1'b1;
        repeat (32) @(negedge clk);
        bad = 0; seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (sel_a != 4'hF && sel_a != 4'hE) bad++;
            if (sel_a == 4'hE) begin
                seen++;
                if (seg_a != 8'h92) bad++;
            end
        end
        check("lz_only_d0", 16'(bad), 16'd0);
        check("lz_d0_shown", 16'(seen), 16'd3);
        data_a = 16'h0000;
        repeat (32) @(negedge clk);
        bad = 0; seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (sel_a != 4'hF && sel_a != 4'hE) bad++;
            if (sel_a == 4'hE && seg_a == 8'hC0) seen++;
        end
        check("lz_zero_others", 16'(bad), 16'd0);
        check("lz_zero_d0", 16'(seen), 16'd3);

        // Per-digit blank and decimal point.
        data_a = 16'h1234; lz_a = 1'b0; blank_a = 4'b0100; dp_a = 4'b0010;
        repeat (32) @(negedge clk);
        bad = 0; seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (sel_a == 4'hB) bad++;
            if (sel_a == 4'hD && seg_a == 8'h30) seen++;
        end
        check("blank_d2", 16'(bad), 16'd0);
        check("dp_d1", 16'(seen), 16'd3);
        blank_a = 4'b0000; dp_a = 4'b0000;

        // Enable drop mid-slot, then re-enable.
        repeat (32) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (sel_a == 4'hE) found = 1'b1;
        end
        check("wait_digit0", {15'd0, found}, 16'd1);
        en_a = 1'b0;
        @(negedge clk);
        check("en_off_sel", {12'd0, sel_a}, 16'h000F);
        check("en_off_seg", {8'd0, seg_a}, 16'h00FF);
        check("en_off_fd", {15'd0, fd_a}, 16'd0);
        repeat (5) @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        check("reen_blank", {12'd0, sel_a}, 16'h000F);
        @(negedge clk);
        check("reen_sel", {12'd0, sel_a}, 16'h000E);
        check("reen_seg", {8'd0, seg_a}, 16'h0099);

        // Asynchronous reset mid-cycle.
        #6;
        check("pre_rst_sel", {12'd0, sel_a}, 16'h000E);
        rst = 1'b1;
        #1;
        check("async_rst_sel_a", {12'd0, sel_a}, 16'h000F);
        check("async_rst_seg_a", {8'd0, seg_a}, 16'h00FF);
        check("async_rst_sel_b", {15'd0, sel_b}, 16'd0);
        check("async_rst_seg_b", {8'd0, seg_b}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                data_a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {rnib(), rnib(), rnib(), rnib()};
            if ($urandom_range(0, 15) == 0) dp_a = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_a = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 31) == 0) lz_a = 1'($urandom);
            if (en_a ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 3) == 0)) en_a = ~en_a;
            if ($urandom_range(0, 5) == 0) data_b = 4'($urandom);
            if ($urandom_range(0, 9) == 0) dp_b = 1'($urandom);
            if ($urandom_range(0, 19) == 0) blank_b = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 9) == 0) lz_b = 1'($urandom);
            if (en_b ? ($urandom_range(0, 40) == 0) : ($urandom_range(0, 2) == 0)) en_b = ~en_b;
            if ($urandom_range(0, 999) == 0) begin
                #7 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dled_scan_ctrl.md
Name: dled_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment scan controller for DIGITS hex digits; successor to the combinational digit selector.
- Owns the scan timing: refresh divider, digit rotation, anti-ghost blanking, frame-coherent data snapshot, hex-to-segment decode, decimal points, per-digit blanking and leading-zero suppression.
- Drives the board's common-anode/cathode LED digit pins directly from registered outputs.

Parameters:
- DIGITS, 8, number of digits (1..16).
- SCAN_DIV, 50000, clock cycles per digit slot (>=2).
- BLANK_CYCLES, 1, cycles at the start of each slot with all digits off (0..SCAN_DIV-1).
- SEG_ACTIVE_LOW, 1, 1 inverts seg outputs (lit = 0).
- SEL_ACTIVE_LOW, 1, 1 inverts sel outputs (selected = 0).

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; 0 turns the display dark.
- disp_data  in  4*DIGITS  hex nibbles; digit i = disp_data[4i+3:4i].
- dp_i  in  DIGITS  decimal point per digit (1 = lit).
- blank_i  in  DIGITS  force digit off (1 = blank).
- lz_en  in  1  leading-zero suppression enable.
- sel  out  DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW.
- seg  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (async, active-high) sets:
  - cnt = 0 and idx = 0.
  - Snapshot registers (data, dp, blank, lz) = 0; load_pend = 1.
  - sel and seg = inactive: all ones when the matching ACTIVE_LOW parameter = 1, else zero.
  - frame_done = 0.
- Divider:
  - cnt counts 0..SCAN_DIV-1 while en = 1 and wraps to 0.
  - On the edge where cnt = SCAN_DIV-1, idx advances and wraps from DIGITS-1 to 0.
  - en = 0 holds cnt = 0 and idx = 0 synchronously.
- Snapshot: disp_data, dp_i, blank_i and lz_en are loaded together on any edge where load_pend = 1, en = 0, or (cnt = SCAN_DIV-1 and idx = DIGITS-1). load_pend clears on the first edge after reset.
  - Inputs may change mid-frame without tearing.
  - A new value is displayed starting from the next frame.
- Effective blank for digit i = snap_blank[i] OR (snap_lz AND i != 0 AND nibbles i..DIGITS-1 are all zero). Digit 0 is never zero-suppressed.
- Output register, updated every edge from current cnt, idx and snapshot (one-cycle latency):
  - Outputs are inactive if en = 0, load_pend = 1, cnt < BLANK_CYCLES, or effective blank[idx] = 1.
  - Otherwise sel = onehot(idx) and seg = {snap_dp[idx], hex7(nibble idx)}.
  - The dp bit is lit only when the digit itself is shown.
- hex7 (active-high, g..a), nibble 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Inversion per parameter is applied after decode.
- frame_done is registered: it is 1 for exactly the cycle after the edge where idx wraps DIGITS-1 -> 0, and 0 while en = 0.
- en falling mid-slot: outputs go inactive on the next edge; scanning restarts at digit 0, cnt 0, on re-enable.
- Reset mid-frame: immediate asynchronous return to reset values.
- At most one sel bit is active on any cycle.

Test Plan:
- Reset/startup (DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, active-low, en=1, disp_data=16'h1234, dp_i=0) -> sel=4'hF and seg=8'hFF during reset and the first two edges after it. Then sel=4'b1110 with seg=8'h99 ('4') for 3 cycles, then blank for 1 cycle, then sel=4'b1101 with seg=8'hB0 ('3').
- Frame coherence: change disp_data to 16'hABCD while idx=2 -> digits 2 and 3 still show '2' and '1'. The next frame shows D, C, b, A (seg 8'hA1, 8'hC6, 8'h83, 8'h88). frame_done pulses exactly once per 16 cycles.
- Leading zeros: disp_data=16'h0005, lz_en=1 -> only sel=4'b1110 is ever active (seg 8'h92). disp_data=16'h0000 -> digit 0 shows '0' (8'hC0).
- Blank and dp: blank_i=4'b0100, dp_i=4'b0010 -> digit 2 is never selected; digit 1 shows seg with bit7=0 (dp lit).
- Enable and reset: en=0 mid-slot -> outputs inactive on the next edge and frame_done=0. Re-enable -> digit 0 is first, after BLANK_CYCLES. Asserting Rst asynchronously mid-cycle -> outputs go inactive without waiting for a clock edge.
- Parameter sweep: DIGITS=1, BLANK_CYCLES=0, SEG/SEL_ACTIVE_LOW=0 -> sel is constantly 1 after startup, seg=8'h06 for data 1, and frame_done pulses every SCAN_DIV cycles.
